// File: rtl/data_mem_dump_if.sv
// Halt-time data-memory port plus the outbound byte channel of the dump unit.
// tx_valid/tx_ready: a byte moves on every cycle where both are high; valid holds until accepted.
interface data_mem_dump_if;
    logic [31:0] mem_address;
    logic        mem_read_enabled;
    logic        mem_write_enabled;
    logic [31:0] mem_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output mem_address, mem_read_enabled, mem_write_enabled, tx_data, tx_valid,
        input  mem_data, tx_ready
    );

    modport slave (
        input  mem_address, mem_read_enabled, mem_write_enabled, tx_data, tx_valid,
        output mem_data, tx_ready
    );
endinterface

// File: rtl/data_mem_dump.sv
// Sweeps data memory from word 0 while the CPU is halted and streams every word
// out MSB first as four bytes over the valid/ready byte channel.
module data_mem_dump #(
    parameter int MEMORY_SIZE = 1024,
    parameter int DUMP_WORDS  = 1024
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    data_mem_dump_if.master bus,
    output logic            busy,
    output logic            done,
    output logic [2:0]      dbg_state
);
    localparam int IDX_W = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(DUMP_WORDS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, LATCH, SEND, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [31:0]      shift;
    logic             xfer;
    logic             last_byte;

    assign xfer      = (state == SEND) && bus.tx_ready;
    assign last_byte = (byte_idx == 2'd3);
    assign dbg_state = state;

    always_comb begin
        state_next            = state;
        bus.mem_address       = '0;
        bus.mem_read_enabled  = 1'b0;
        bus.mem_write_enabled = 1'b0;
        bus.tx_data           = '0;
        bus.tx_valid          = 1'b0;
        busy                  = 1'b0;
        done                  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ADDR;
            end
            // Address is held through LATCH so a registered memory has its data ready too.
            ADDR, LATCH: begin
                bus.mem_address      = 32'(word_idx);
                bus.mem_read_enabled = 1'b1;
                busy                 = 1'b1;
                state_next           = (state == ADDR) ? LATCH : SEND;
            end
            SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = shift[31:24];
                busy         = 1'b1;
                if (xfer && last_byte) state_next = (word_idx == LAST_WORD) ? DONE : ADDR;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            word_idx <= '0;
            byte_idx <= '0;
            shift    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) word_idx <= '0;
                end
                LATCH: begin
                    shift    <= bus.mem_data;
                    byte_idx <= '0;
                end
                SEND: begin
                    if (xfer) begin
                        shift    <= shift << 8;
                        byte_idx <= byte_idx + 2'd1;
                        // Termination is by the last-word compare only, so the index never wraps.
                        if (last_byte && (word_idx != LAST_WORD)) word_idx <= word_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_dump.sv
// Bench for data_mem_dump: a 2-word dump over a registered-read memory and a
// full 4-word dump over a combinational-read memory, with random back-pressure.
module tb_data_mem_dump;
    logic clock;
    logic reset;
    logic start;
    logic ready;
    logic sel;

    logic       start_a, start_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [2:0] state_a, state_b;

    data_mem_dump_if bus_a();
    data_mem_dump_if bus_b();

    data_mem_dump #(.MEMORY_SIZE(16), .DUMP_WORDS(2)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .bus(bus_a),
        .busy(busy_a), .done(done_a), .dbg_state(state_a)
    );

    data_mem_dump #(.MEMORY_SIZE(4), .DUMP_WORDS(4)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .bus(bus_b),
        .busy(busy_b), .done(done_b), .dbg_state(state_b)
    );

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [4];
    logic [31:0] rd_a;

    assign start_a        = start && !sel;
    assign start_b        = start && sel;
    assign bus_a.tx_ready = ready;
    assign bus_b.tx_ready = ready;
    assign bus_a.mem_data = rd_a;
    assign bus_b.mem_data = mem_b[bus_b.mem_address[1:0]];

    always @(posedge clock) begin
        if (bus_a.mem_read_enabled) rd_a <= mem_a[bus_a.mem_address[3:0]];
    end

    // ---------------- clock / reset ----------------
    int cyc;
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_checks, n_err;
    int n_bytes, done_cnt, done_cyc, busy_cnt, stall_cnt, valid_seen, first_valid, start_cyc;
    logic addr_seen, hold_pending;
    logic [31:0] first_addr;
    logic [7:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] o_addr;
    logic        o_rd, o_valid, o_busy, o_done;
    logic [7:0]  o_data;
    always_comb begin
        o_addr  = sel ? bus_b.mem_address      : bus_a.mem_address;
        o_rd    = sel ? bus_b.mem_read_enabled : bus_a.mem_read_enabled;
        o_data  = sel ? bus_b.tx_data          : bus_a.tx_data;
        o_valid = sel ? bus_b.tx_valid         : bus_a.tx_valid;
        o_busy  = sel ? busy_b                 : busy_a;
        o_done  = sel ? done_b                 : done_a;
    end

    always @(negedge clock) begin
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            check("we_a", {63'd0, bus_a.mem_write_enabled}, 64'd0);
            check("we_b", {63'd0, bus_b.mem_write_enabled}, 64'd0);
            check("addr_b_range", {63'd0, bus_b.mem_address <= 32'd3}, 64'd1);
            if (!o_busy) check("idle_out", {22'd0, o_addr, o_rd, o_data, o_valid}, 64'd0);
            if (hold_pending) begin
                check("hold_valid", {63'd0, o_valid}, 64'd1);
                check("hold_data", {56'd0, o_data}, {56'd0, held});
            end
            hold_pending = o_valid && !ready;
            held         = o_data;
            if (o_valid) begin
                valid_seen++;
                if (first_valid < 0) first_valid = cyc;
                if (!ready) stall_cnt++;
            end
            if (o_valid && ready) begin
                n_bytes++;
                if (exp_q.size() == 0) check("extra_byte", {56'd0, o_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                else check("byte", {56'd0, o_data}, {56'd0, exp_q.pop_front()});
            end
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (o_rd && !addr_seen) begin
                addr_seen  = 1'b1;
                first_addr = o_addr;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_stats();
        n_bytes = 0; done_cnt = 0; done_cyc = 0; busy_cnt = 0; stall_cnt = 0;
        valid_seen = 0; first_valid = -1; addr_seen = 1'b0; first_addr = '0;
    endtask

    task automatic load_expected(input int n);
        logic [31:0] word;
        exp_q.delete();
        for (int w = 0; w < n; w++) begin
            word = sel ? mem_b[w] : mem_a[w];
            for (int b = 0; b < 4; b++) exp_q.push_back(8'(word >> (24 - 8 * b)));
        end
    endtask

    task automatic pulse_start();
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    // mode 0: ready high, 1: random ready, 2: three stalls on first byte, 3: re-start during SEND
    task automatic run_dump(input int mode);
        int n;
        n = sel ? 4 : 2;
        load_expected(n);
        clear_stats();
        ready = (mode == 2) ? 1'b0 : 1'b1;
        pulse_start();
        for (int c = 0; c < 400 && done_cnt == 0; c++) begin
            @(posedge clock); #1;
            case (mode)
                1:       ready = ($urandom_range(0, 3) != 0);
                2:       ready = (valid_seen >= 3);
                default: ready = 1'b1;
            endcase
            start = (mode == 3) && (cyc == start_cyc + 3);
        end
        start = 1'b0;
        ready = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        check("done_cnt", done_cnt, 1);
        check("bytes", n_bytes, 4 * n);
        check("q_left", exp_q.size(), 0);
        check("done_lat", done_cyc - start_cyc, 6 * n + stall_cnt);
        check("busy_cyc", busy_cnt, 6 * n + stall_cnt);
        check("first_valid", first_valid - start_cyc, 2);
        check("first_addr", {32'd0, first_addr}, 64'd0);
        if (mode == 2) check("stalls", stall_cnt, 3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0; n_err = 0;
        reset = 1'b1; start = 1'b0; ready = 1'b1; sel = 1'b0; cyc = 0;
        for (int i = 0; i < 16; i++) mem_a[i] = $urandom;
        for (int i = 0; i < 4; i++)  mem_b[i] = $urandom;
        clear_stats();
        repeat (3) @(posedge clock);
        #1;
        check("rst_a", {19'd0, bus_a.mem_address, bus_a.mem_read_enabled, bus_a.mem_write_enabled,
                        bus_a.tx_data, bus_a.tx_valid, busy_a, done_a}, 64'd0);
        check("rst_b", {19'd0, bus_b.mem_address, bus_b.mem_read_enabled, bus_b.mem_write_enabled,
                        bus_b.tx_data, bus_b.tx_valid, busy_b, done_b}, 64'd0);
        reset = 1'b0;

        sel = 1'b0;
        mem_a[0] = 32'h1234_5678;
        mem_a[1] = 32'hDEAD_BEEF;
        run_dump(0);

        mem_a[0] = 32'hA1B2_C3D4;
        run_dump(2);
        run_dump(3);

        // Reset lands in LATCH of word 1; the dump must abort without a done pulse.
        load_expected(2);
        clear_stats();
        ready = 1'b1;
        pulse_start();
        repeat (7) @(posedge clock);
        #1;
        check("pre_rst_rd", {63'd0, bus_a.mem_read_enabled}, 64'd1);
        check("pre_rst_addr", {32'd0, bus_a.mem_address}, 64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("mid_rst_out", {19'd0, bus_a.mem_address, bus_a.mem_read_enabled, bus_a.mem_write_enabled,
                              bus_a.tx_data, bus_a.tx_valid, busy_a, done_a}, 64'd0);
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("rst_no_done", done_cnt, 0);
        check("rst_bytes", n_bytes, 4);
        run_dump(0);

        sel = 1'b1;
        mem_b[0] = 32'h0000_0000;
        mem_b[1] = 32'h0000_0001;
        mem_b[2] = 32'h0000_0002;
        mem_b[3] = 32'hFFFF_FFFF;
        run_dump(0);

        for (int r = 0; r < 8; r++) begin
            sel = r[0];
            for (int i = 0; i < 16; i++) mem_a[i] = $urandom;
            for (int i = 0; i < 4; i++)  mem_b[i] = $urandom;
            run_dump(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
